// File: rtl/board_pkg.sv
// Shared definitions for the board write path.
// Holds the board geometry, address/data widths, the block-type codes stored
// in Board_RAM, and the sequencer state type. No ports; imported by the
// sequencer and its arbiter.
package board_pkg;

  localparam int BOARD_COLS = 32;
  localparam int BOARD_ROWS = 24;
  localparam int NUM_BLOCKS = BOARD_COLS * BOARD_ROWS;  // 768
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 4;
  localparam int COUNT_W    = 10;

  // Block codes as stored in Board_RAM.
  typedef enum logic [DATA_W-1:0] {
    BLK_EMPTY  = 4'd0,
    BLK_PELLET = 4'd1,
    BLK_WALL   = 4'd2,
    BLK_POWER  = 4'd3
  } block_t;

  localparam logic [DATA_W-1:0] PELLET_TYPE = BLK_PELLET;
  localparam logic [DATA_W-1:0] EMPTY_TYPE  = BLK_EMPTY;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/board_write_sequencer_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - arbitration allowed this cycle
//   req[1:0]    - raw requests
//   ack[1:0]    - acks currently being presented; an acked requester is
//                 masked so it is not granted again while it drops req
//   gnt_valid   - a grant is issued at the coming edge
//   gnt_idx     - which requester is granted
// The last-grant register resets to 1 so that requester 0 wins the first tie.
module rr_arb2
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] ack,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] elig;
  logic       last_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign elig[gi] = en & req[gi] & ~ack[gi];
  end

  always_comb begin
    gnt_valid = |elig;
    gnt_idx   = 1'b0;
    if (elig == 2'b11) begin
      gnt_idx = ~last_reg;
    end else if (elig[1]) begin
      gnt_idx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (gnt_valid) begin
      last_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/board_write_sequencer.sv
// board_write_sequencer: owns the single write port shared by both Board_RAM
// copies. After reset or start_init it copies the 768-entry init ROM into the
// RAMs while counting pellets, then arbitrates run-time writes from two
// requesters and keeps a live pellet count.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start_init            - one-cycle pulse, reload board from ROM
//   rom_addr / rom_q      - init ROM address out, data in (1-cycle latency)
//   req0/addr0/data0/consume0/ack0 - requester 0 (pacman / gameLogic)
//   req1/addr1/data1/ack1          - requester 1 (ghost / aux logic)
//   wr_en/wr_addr/wr_data - RAM write port
//   ready                 - high while in RUN
//   pellet_count          - pellets remaining
//   board_clear           - ready && pellet_count == 0
module board_write_sequencer
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_init,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              consume0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic [9:0]        pellet_count,
  output logic              board_clear
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  seq_state_t         state_reg, state_next;
  logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
  logic               wr_en_reg, wr_en_next;
  logic               init_wr_reg, init_wr_next;
  logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0]  run_data_reg, run_data_next;
  logic               ack0_reg, ack0_next;
  logic               ack1_reg, ack1_next;
  logic               ready_reg, ready_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               clear_reg, clear_next;

  logic               arb_en;
  logic               gnt_valid;
  logic               gnt_idx;

  // A start_init pulse drops pending requests, so no grant is issued with it.
  assign arb_en = (state_reg == ST_RUN) && !start_init;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .en        (arb_en),
    .req       ({req1, req0}),
    .ack       ({ack1_reg, ack0_reg}),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    wr_en_next    = 1'b0;
    init_wr_next  = 1'b0;
    wr_addr_next  = wr_addr_reg;
    run_data_next = run_data_reg;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    ready_next    = ready_reg;
    count_next    = count_reg;

    // The init write in flight this cycle carries rom_q; count it here so the
    // last write (issued in DRAIN) is included.
    if (init_wr_reg && (rom_q == PELLET_TYPE)) begin
      count_next = count_reg + CNT_ONE;
    end

    if (start_init) begin
      state_next    = ST_INIT;
      rom_addr_next = '0;
      ready_next    = 1'b0;
      count_next    = '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          wr_en_next   = 1'b1;
          init_wr_next = 1'b1;
          wr_addr_next = rom_addr_reg;
          if (rom_addr_reg == LAST_ADDR) begin
            state_next    = ST_DRAIN;
            rom_addr_next = '0;
          end else begin
            rom_addr_next = rom_addr_reg + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          state_next = ST_RUN;
          ready_next = 1'b1;
        end
        ST_RUN: begin
          if (gnt_valid) begin
            wr_en_next = 1'b1;
            if (gnt_idx) begin
              ack1_next     = 1'b1;
              wr_addr_next  = addr1;
              run_data_next = data1;
            end else begin
              ack0_next     = 1'b1;
              wr_addr_next  = addr0;
              run_data_next = data0;
              if (consume0 && (data0 == EMPTY_TYPE) && (count_reg != '0)) begin
                count_next = count_reg - CNT_ONE;
              end
            end
          end
        end
        default: begin
          state_next = ST_INIT;
        end
      endcase
    end

    clear_next = ready_next && (count_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_INIT;
      rom_addr_reg <= '0;
      wr_en_reg    <= 1'b0;
      init_wr_reg  <= 1'b0;
      wr_addr_reg  <= '0;
      run_data_reg <= '0;
      ack0_reg     <= 1'b0;
      ack1_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      count_reg    <= '0;
      clear_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      wr_en_reg    <= wr_en_next;
      init_wr_reg  <= init_wr_next;
      wr_addr_reg  <= wr_addr_next;
      run_data_reg <= run_data_next;
      ack0_reg     <= ack0_next;
      ack1_reg     <= ack1_next;
      ready_reg    <= ready_next;
      count_reg    <= count_next;
      clear_reg    <= clear_next;
    end
  end

  assign rom_addr     = rom_addr_reg;
  assign wr_en        = wr_en_reg;
  assign wr_addr      = wr_addr_reg;
  // During init the data comes straight from the ROM's registered output,
  // which is aligned with the delayed address; otherwise it is the latched
  // requester data.
  assign wr_data      = init_wr_reg ? rom_q : run_data_reg;
  assign ack0         = ack0_reg;
  assign ack1         = ack1_reg;
  assign ready        = ready_reg;
  assign pellet_count = count_reg;
  assign board_clear  = clear_reg;

endmodule
